// File: rtl/integral_pkg.sv
// Shared types and defaults for the integral-image memory path.
package integral_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 8;
    localparam int READ_LAT_DEF  = 2;
    localparam int VID_IN_WIDTH  = 16;
    localparam int VID_IN_HEIGHT = 16;

    typedef enum logic {
        REQ_ENGINE   = 1'b0,
        REQ_DETECTOR = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/integral_rsp_pipe.sv
// Tag shift register that times read responses and steers them to the
// requester that issued the read.
module integral_rsp_pipe
    import integral_pkg::*;
#(
    parameter int unsigned DEPTH = READ_LAT_DEF - 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_id,
    output logic rsp0_valid,
    output logic rsp1_valid
);

    rsp_tag_t             in_tag;
    rsp_tag_t [DEPTH-1:0] stage;

    always_comb begin
        in_tag.valid = in_valid;
        in_tag.id    = req_id_t'(in_id);
    end

    generate
        if (DEPTH > 1) begin : g_shift
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage <= '0;
                end else begin
                    stage <= {stage[DEPTH-2:0], in_tag};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage <= '0;
                end else begin
                    stage[0] <= in_tag;
                end
            end
        end
    endgenerate

    always_comb begin
        rsp0_valid = stage[DEPTH-1].valid && (stage[DEPTH-1].id == REQ_ENGINE);
        rsp1_valid = stage[DEPTH-1].valid && (stage[DEPTH-1].id == REQ_DETECTOR);
    end

endmodule

// File: rtl/integral_mem_arbiter.sv
// Two-requester arbiter for the integral-image M10K port with tagged,
// fixed-latency read responses. INTEGRAL_ARB_RR_EN selects round-robin arbitration.
module integral_mem_arbiter
    import integral_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              issue_valid;
    logic              issue_id;
    logic [DATA_W-1:0] held0;
    logic [DATA_W-1:0] held1;

`ifdef INTEGRAL_ARB_RR_EN
    // prio names the requester that wins a tie: the one not granted last.
    logic prio;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio);
        grant1 = req1_valid && (!req0_valid || prio);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        accept     = grant0 || grant1;
        sel_we     = grant0 ? req0_we    : req1_we;
        sel_addr   = grant0 ? req0_addr  : req1_addr;
        sel_wdata  = grant0 ? req0_wdata : req1_wdata;
    end

    // Reads and writes share this single register stage, so memory sees
    // accesses in exactly the order they were granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            mem_write         <= 1'b0;
            issue_valid       <= 1'b0;
            issue_id          <= 1'b0;
        end else begin
            mem_write   <= accept && sel_we;
            issue_valid <= accept && !sel_we;
            issue_id    <= grant1;
            if (accept && sel_we) begin
                mem_write_address <= sel_addr;
                mem_write_data    <= sel_wdata;
            end
            if (accept && !sel_we) begin
                mem_read_address <= sel_addr;
            end
        end
    end

    integral_rsp_pipe #(
        .DEPTH(READ_LAT - 1)
    ) u_rsp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_id     (issue_id),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            held0 <= '0;
            held1 <= '0;
        end else begin
            if (rsp0_valid) held0 <= mem_read_data;
            if (rsp1_valid) held1 <= mem_read_data;
        end
    end

    always_comb begin
        rsp0_data = rsp0_valid ? mem_read_data : held0;
        rsp1_data = rsp1_valid ? mem_read_data : held1;
    end

endmodule

// File: doc/integral_mem_arbiter.md
Name: integral_mem_arbiter

Overview:
- Shares the single read/write port of the integral-image M10K between two requesters:
  - requester 0: the integral compute engine, read+write;
  - requester 1: the detector/readout path, read+write, normally read-only.
- One grant per cycle, valid/ready request handshake, fixed-latency tagged read responses.
- Sits between both requesters and the M10K instance. Replaces direct wiring of the engine's address/write outputs to the memory.

Parameters:
- ADDR_W, 8, M10K word address width (256 words)
- DATA_W, 8, signed data width
- READ_LAT, 2, cycles from request acceptance to response valid (1 registered address stage + 1 M10K read cycle); legal 2..4

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 request present
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_we  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  word address
- req0_wdata  in  DATA_W  write data
- rsp0_valid  out  1  read data valid for requester 0
- rsp0_data  out  DATA_W  read data for requester 0
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_data: same as requester 0, for requester 1
- mem_read_address  out  ADDR_W  M10K read address
- mem_write_address  out  ADDR_W  M10K write address
- mem_write  out  1  M10K write enable
- mem_write_data  out  DATA_W  M10K write data
- mem_read_data  in  DATA_W  M10K registered read data

Behaviour:
- Reset: all memory-side outputs 0, rsp*_valid 0, rsp*_data 0, response pipe cleared, round-robin pointer set to requester 0. Reset mid-operation drops in-flight reads; no rsp*_valid fires after reset.
- Arbitration is combinational on the valid inputs:
  - reqN_ready = grant to N;
  - at most one ready per cycle;
  - a request is accepted in cycle T when valid && ready.
- Default policy is fixed priority, requester 0 wins. Requester 1 is granted only when req0_valid=0.
- Requesters must hold their address, data and we stable while valid && !ready. The arbiter holds no request buffer.
- Accepted write at T:
  - at edge T+1: mem_write_address/mem_write_data are loaded and mem_write=1 for exactly one cycle;
  - no response is produced.
- Accepted read at T:
  - at edge T+1: mem_read_address is loaded and a tag {valid, id} enters the response pipe;
  - in cycle T+READ_LAT: rspID_valid=1 for one cycle, and rspID_data = mem_read_data sampled in that cycle;
  - the other requester's rsp_valid stays 0.
- mem_read_address holds its last value when idle. mem_write=0 on idle cycles and on read grants.
- Responses carry no backpressure; requesters must accept them.
- Memory ordering equals grant order.
  - Write at T then read of the same address at T+1 returns the new value, because both pass through the same single register stage.
  - Write and read of the same address accepted in one cycle cannot occur (single grant).
- Throughput: one access per cycle sustained. Back-to-back reads produce back-to-back responses.
- rsp*_data holds its last value when rsp*_valid=0.

Optional Feature:
- Macro INTEGRAL_ARB_RR_EN.
- Defined: round-robin policy.
  - When both are valid, grant goes to the requester not granted most recently.
  - The pointer updates only on an accepted request.
  - A lone valid requester is always granted.
- Undefined: fixed priority, requester 0 wins. No pointer register is synthesized.

Decomposition:
- Shared package integral_pkg holds:
  - ADDR_W/DATA_W defaults, VID_IN_WIDTH/VID_IN_HEIGHT;
  - a 1-bit requester-id typedef;
  - the READ_LAT default.
- One sub-module, integral_rsp_pipe: a READ_LAT-1-deep shift register of {valid, id} tags. It provides the response steering and the reset clear.

Test Plan:
- Reset, then req0 read of addr 0x05 with mem holding 0x12 → req0_ready=1 at T, mem_read_address=0x05 after edge T+1, rsp0_valid=1 with rsp0_data=0x12 at T+2, rsp1_valid=0 throughout.
- req0 write addr 0x10 data 0x7F, then req0 read addr 0x10 the next cycle → mem_write=1 for one cycle with address 0x10 and data 0x7F, then rsp0_data=0x7F two cycles after the read is accepted.
- Both valid for 4 cycles, fixed priority → only req0_ready asserted and req1 stalls. With INTEGRAL_ARB_RR_EN → grants alternate 0,1,0,1.
- Interleaved reads (req0 addr 1, req1 addr 2, req0 addr 3) on consecutive cycles → responses on consecutive cycles tagged 0,1,0 with data mem[1], mem[2], mem[3].
- Reset asserted one cycle after a read is accepted → no rsp_valid afterwards, all outputs 0.
- req1 held valid while req0 idle → req1 granted every cycle, 256 sequential reads addr 0..255 complete in 256+READ_LAT cycles.
